// File: rtl/pe_dbuf.sv
// Systolic MAC PE with double-buffered weight (shadow chain + active); PE_DBUF_SATURATE_EN selects saturating accumulate.
// Latency: every output registered, one cycle. Backpressure: none; active=0 freezes dataout/maccout, weight/control paths run.
module pe_dbuf #(
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     active,
    input  logic signed [DATA_W-1:0] datain,
    input  logic signed [ACC_W-1:0]  sumin,
    input  logic signed [WGT_W-1:0]  win,
    input  logic                     wload,
    input  logic                     wswap,
    output logic signed [DATA_W-1:0] dataout,
    output logic signed [ACC_W-1:0]  maccout,
    output logic signed [WGT_W-1:0]  wout,
    output logic                     wloadout,
    output logic                     wswapout,
    output logic                     activeout,
    output logic                     ovf
);
    localparam int PROD_W = DATA_W + WGT_W;

    if (ACC_W < PROD_W) begin : g_acc_w_check
        $error("pe_dbuf: ACC_W must be >= DATA_W+WGT_W");
    end

    logic signed [DATA_W-1:0] dataout_q;
    logic signed [ACC_W-1:0]  macc_q, macc_d;
    logic signed [WGT_W-1:0]  shadow_q, wout_q, weight_q;
    logic                     wload_q, wswap_q, active_q, ovf_q;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext, sum_raw;
    logic                     ovf_c;

    always_comb begin
        prod     = PROD_W'(datain) * PROD_W'(weight_q);
        prod_ext = ACC_W'(prod);
        sum_raw  = sumin + prod_ext;
        // Signed overflow: like-signed addends producing a result of the other sign.
        ovf_c    = (sumin[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum_raw[ACC_W-1] != sumin[ACC_W-1]);
        macc_d   = sum_raw;
`ifdef PE_DBUF_SATURATE_EN
        if (ovf_c) begin
            macc_d = sumin[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataout_q <= '0;
            macc_q    <= '0;
            shadow_q  <= '0;
            wout_q    <= '0;
            weight_q  <= '0;
            wload_q   <= 1'b0;
            wswap_q   <= 1'b0;
            active_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            active_q <= active;
            wload_q  <= wload;
            wswap_q  <= wswap;
            if (active) begin
                dataout_q <= datain;
                macc_q    <= macc_d;
                ovf_q     <= ovf_q | ovf_c;
            end
            // Swap and shift may coincide: weight takes the pre-edge shadow.
            if (wswap) begin
                weight_q <= shadow_q;
            end
            if (wload) begin
                shadow_q <= win;
                wout_q   <= shadow_q;
            end
        end
    end

    assign dataout   = dataout_q;
    assign maccout   = macc_q;
    assign wout      = wout_q;
    assign wloadout  = wload_q;
    assign wswapout  = wswap_q;
    assign activeout = active_q;
    assign ovf       = ovf_q;
endmodule

// File: doc/pe_dbuf.md
Name: pe_dbuf

Overview:
- Parametrised systolic MAC processing element; next generation of the matrix multiply unit PE.
- Adds generic data, weight and accumulator widths, asynchronous reset, and a double-buffered weight (shadow plus active).
- A new weight column can be shifted in while the current tile is still computing, then swapped in with a wavefront-aligned swap pulse.
- Tiled into an N x N array by the MMU: data flows right, weights and partial sums flow down.

Parameters:
- DATA_W, 8, signed activation width.
- WGT_W, 8, signed weight width.
- ACC_W, 16, signed partial-sum width; must be >= DATA_W+WGT_W (elaboration-time check, $error on violation).

Ports:
- clk  in  1  global clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- active  in  1  compute enable for this cycle.
- datain  in  DATA_W  signed activation from the left.
- sumin  in  ACC_W  signed partial sum from above.
- win  in  WGT_W  weight shift-chain input from above.
- wload  in  1  shift enable for the weight shadow chain.
- wswap  in  1  copy shadow weight to active weight.
- dataout  out  DATA_W  registered activation to the right.
- maccout  out  ACC_W  registered sumin + datain*weight to below.
- wout  out  WGT_W  registered shadow value to the PE below.
- wloadout  out  1  registered wload.
- wswapout  out  1  registered wswap; aligned with dataout for diagonal wavefront.
- activeout  out  1  registered active.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (rst_n=0, asynchronous): every output register, shadow and weight clear to 0; ovf=0. Reset mid-operation discards any in-flight load or swap. First capture occurs on the first rising clk edge after rst_n deasserts.
- All outputs are registered, one cycle latency. No combinational input-to-output paths.
- Control pipeline: activeout<=active, wloadout<=wload, wswapout<=wswap every cycle, independent of active.
- Compute, active=1:
  - dataout<=datain.
  - maccout<=sumin + sext(datain*weight).
  - The product is full DATA_W+WGT_W signed, sign-extended to ACC_W. The add is ACC_W bits, wrapping (two's complement) unless SATURATE_EN.
- Stall, active=0: dataout and maccout hold their previous values (pipeline freeze); weight path is unaffected.
- Weight chain, wload=1: shadow<=win and wout<=shadow (old value), so an N-deep column fills in N cycles. With wload=0, shadow and wout hold; no filler pattern is driven.
- Swap, wswap=1: weight<=shadow (value before this edge). A MAC in the same cycle uses the old weight; the new weight is used from the next cycle.
- wload and wswap in the same cycle: swap takes the old shadow, shadow takes win. Both happen.
- Overflow (wrap mode): ovf sets when active=1, both addends have the same sign, and the result sign differs. Cleared only by reset.

Optional Feature:
- Macro: PE_DBUF_SATURATE_EN.
- Defined: the accumulate saturates to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) on overflow, and ovf still sets.
- Undefined: wrapping add as above; ovf still sets.

Test Plan:
- Reset: drive random inputs, pulse rst_n low mid-cycle -> all outputs 0 immediately (no clk edge needed); weight=0, so an active cycle with datain=5, sumin=7 gives maccout=7.
- Load and swap: wload=1, win=3 for one cycle, then wload=0 -> wout=0 on that edge, wout=3 after the next load cycle. Then wswap=1 with datain=4, sumin=10 -> maccout=10. Next cycle, same inputs -> maccout=22.
- Sign handling: weight=-128, datain=-128, sumin=0 -> maccout=16384. Weight=127, datain=-1, sumin=-5 -> maccout=-132.
- Stall: active=1 with datain=2, sumin=1, weight=6 -> maccout=13, dataout=2. Then active=0 with datain=9 for 3 cycles -> maccout=13 and dataout=2 hold, activeout=0.
- Simultaneous load and swap: shadow=7, win=11, wload=1 and wswap=1 -> weight=7, shadow=11, wout=7, wswapout=1 on the next edge.
- Overflow: weight=127, datain=127 (product 16129), sumin=20000 -> wrap build gives maccout=-29407 and ovf=1; SATURATE_EN build gives maccout=32767 and ovf=1.
